// File: rtl/otter_pkg.sv
// Shared types and encodings for the OTTER multicycle control unit.
package otter_pkg;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011
    } opcode_t;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_TRAP  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_JUMP    = 3'd1,
        CLS_BRANCH  = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_ILLEGAL = 3'd5
    } instr_class_t;

    localparam logic [3:0] ALU_ADD      = 4'd0;
    localparam logic [3:0] ALU_SLL      = 4'd1;
    localparam logic [3:0] ALU_SLT      = 4'd2;
    localparam logic [3:0] ALU_SLTU     = 4'd3;
    localparam logic [3:0] ALU_XOR      = 4'd4;
    localparam logic [3:0] ALU_SRL      = 4'd5;
    localparam logic [3:0] ALU_OR       = 4'd6;
    localparam logic [3:0] ALU_AND      = 4'd7;
    localparam logic [3:0] ALU_SUB      = 4'd8;
    localparam logic [3:0] ALU_LUI_COPY = 4'd9;
    localparam logic [3:0] ALU_SRA      = 4'd13;

    localparam logic [2:0] PC_SEL_PC4    = 3'd0;
    localparam logic [2:0] PC_SEL_JALR   = 3'd1;
    localparam logic [2:0] PC_SEL_BRANCH = 3'd2;
    localparam logic [2:0] PC_SEL_JAL    = 3'd3;

    localparam logic [1:0] SRCA_RS1  = 2'd0;
    localparam logic [1:0] SRCA_UIMM = 2'd1;

    localparam logic [2:0] SRCB_RS2  = 3'd0;
    localparam logic [2:0] SRCB_IIMM = 3'd1;
    localparam logic [2:0] SRCB_SIMM = 3'd2;
    localparam logic [2:0] SRCB_PC   = 3'd3;

    localparam logic [1:0] RF_WR_PC4 = 2'd0;
    localparam logic [1:0] RF_WR_MEM = 2'd2;
    localparam logic [1:0] RF_WR_ALU = 2'd3;

    // Branch resolution from the external comparator flags; funct3 2/3 never reach here.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic eq,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'd0:    taken = eq;
            3'd1:    taken = ~eq;
            3'd4:    taken = lt;
            3'd5:    taken = ~lt;
            3'd6:    taken = ltu;
            3'd7:    taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/otter_ctrl_dcdr.sv
// Combinational instruction decode: datapath selects and instruction class.
module otter_ctrl_dcdr
    import otter_pkg::*;
(
    input  logic [31:0]  ir,
    input  logic         br_eq,
    input  logic         br_lt,
    input  logic         br_ltu,
    output logic [3:0]   alu_fun,
    output logic [1:0]   srca_sel,
    output logic [2:0]   srcb_sel,
    output logic [2:0]   pc_sel,
    output logic [1:0]   rf_wr_sel,
    output instr_class_t instr_class
);

    logic [2:0] funct3;
    logic       unused_ir;

    assign funct3    = ir[14:12];
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    // Opcode decode; anything unrecognised is classed illegal.
    always_comb begin
        alu_fun     = ALU_ADD;
        srca_sel    = SRCA_RS1;
        srcb_sel    = SRCB_RS2;
        pc_sel      = PC_SEL_PC4;
        rf_wr_sel   = RF_WR_ALU;
        instr_class = CLS_ILLEGAL;
        case (ir[6:0])
            OPC_OP: begin
                alu_fun     = {ir[30], funct3};
                instr_class = CLS_ALU;
            end
            OPC_OP_IMM: begin
                // ir[30] only selects SRAI; ADDI with imm[10]=1 must stay ADD.
                alu_fun     = {ir[30] & (funct3 == 3'd5), funct3};
                srcb_sel    = SRCB_IIMM;
                instr_class = CLS_ALU;
            end
            OPC_LUI: begin
                alu_fun     = ALU_LUI_COPY;
                srca_sel    = SRCA_UIMM;
                instr_class = CLS_ALU;
            end
            OPC_AUIPC: begin
                srca_sel    = SRCA_UIMM;
                srcb_sel    = SRCB_PC;
                instr_class = CLS_ALU;
            end
            OPC_JAL: begin
                rf_wr_sel   = RF_WR_PC4;
                pc_sel      = PC_SEL_JAL;
                instr_class = CLS_JUMP;
            end
            OPC_JALR: begin
                rf_wr_sel   = RF_WR_PC4;
                pc_sel      = PC_SEL_JALR;
                instr_class = CLS_JUMP;
            end
            OPC_BRANCH: begin
                if (funct3 == 3'd2 || funct3 == 3'd3) begin
                    instr_class = CLS_ILLEGAL;
                end else begin
                    instr_class = CLS_BRANCH;
                    if (branch_taken(funct3, br_eq, br_lt, br_ltu)) begin
                        pc_sel = PC_SEL_BRANCH;
                    end
                end
            end
            OPC_LOAD: begin
                srcb_sel    = SRCB_IIMM;
                rf_wr_sel   = RF_WR_MEM;
                instr_class = CLS_LOAD;
            end
            OPC_STORE: begin
                srcb_sel    = SRCB_SIMM;
                instr_class = CLS_STORE;
            end
            default: begin
                instr_class = CLS_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/otter_ctrl_fsm.sv
// OTTER multicycle control FSM: sequencing and enable gating around the decoder.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_FETCH | instruction read, wait for MEM_ACK
// ST_EXEC  | decode, drive ALU/selects, retire non-memory instructions
// ST_MEM   | data access in progress, wait for MEM_ACK
// ST_WB    | load data written to register file, PC advanced
// ST_TRAP  | illegal instruction seen; parked (or one-cycle exit)
module otter_ctrl_fsm
    import otter_pkg::*;
#(
    parameter bit RESET_TRAP_EXIT = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] IR,
    input  logic        MEM_ACK,
    input  logic        BR_EQ,
    input  logic        BR_LT,
    input  logic        BR_LTU,
    output logic [3:0]  ALU_FUN,
    output logic [1:0]  SRCA_SEL,
    output logic [2:0]  SRCB_SEL,
    output logic [2:0]  PC_SEL,
    output logic        PC_WE,
    output logic        REG_WE,
    output logic [1:0]  RF_WR_SEL,
    output logic        MEM_RDEN1,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic        ILLEGAL
);

    state_t       state;
    state_t       state_nxt;
    logic         illegal_q;

    logic [3:0]   dec_alu_fun;
    logic [1:0]   dec_srca_sel;
    logic [2:0]   dec_srcb_sel;
    logic [2:0]   dec_pc_sel;
    logic [1:0]   dec_rf_wr_sel;
    instr_class_t dec_class;

    otter_ctrl_dcdr u_dcdr (
        .ir          (IR),
        .br_eq       (BR_EQ),
        .br_lt       (BR_LT),
        .br_ltu      (BR_LTU),
        .alu_fun     (dec_alu_fun),
        .srca_sel    (dec_srca_sel),
        .srcb_sel    (dec_srcb_sel),
        .pc_sel      (dec_pc_sel),
        .rf_wr_sel   (dec_rf_wr_sel),
        .instr_class (dec_class)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Sticky illegal flag, set when an illegal instruction is decoded in EXEC.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            illegal_q <= 1'b0;
        end else if (state == ST_EXEC && dec_class == CLS_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    // Next state and outputs; reset forces every output low combinationally.
    always_comb begin
        state_nxt = state;
        ALU_FUN   = ALU_ADD;
        SRCA_SEL  = SRCA_RS1;
        SRCB_SEL  = SRCB_RS2;
        PC_SEL    = PC_SEL_PC4;
        RF_WR_SEL = RF_WR_PC4;
        PC_WE     = 1'b0;
        REG_WE    = 1'b0;
        MEM_RDEN1 = 1'b0;
        MEM_RDEN2 = 1'b0;
        MEM_WE2   = 1'b0;
        ILLEGAL   = illegal_q;
        case (state)
            ST_FETCH: begin
                MEM_RDEN1 = 1'b1;
                if (MEM_ACK) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ALU_FUN   = dec_alu_fun;
                SRCA_SEL  = dec_srca_sel;
                SRCB_SEL  = dec_srcb_sel;
                PC_SEL    = dec_pc_sel;
                RF_WR_SEL = dec_rf_wr_sel;
                case (dec_class)
                    CLS_ALU, CLS_JUMP: begin
                        REG_WE    = 1'b1;
                        PC_WE     = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                    CLS_BRANCH: begin
                        PC_WE     = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                    CLS_LOAD: begin
                        MEM_RDEN2 = 1'b1;
                        state_nxt = ST_MEM;
                    end
                    CLS_STORE: begin
                        MEM_WE2   = 1'b1;
                        state_nxt = ST_MEM;
                    end
                    default: begin
                        state_nxt = ST_TRAP;
                    end
                endcase
            end
            ST_MEM: begin
                // IR is still held, so the decoder keeps address selects stable.
                ALU_FUN  = dec_alu_fun;
                SRCB_SEL = dec_srcb_sel;
                if (dec_class == CLS_LOAD) begin
                    MEM_RDEN2 = 1'b1;
                    if (MEM_ACK) begin
                        state_nxt = ST_WB;
                    end
                end else begin
                    MEM_WE2 = 1'b1;
                    if (MEM_ACK) begin
                        PC_WE     = 1'b1;
                        state_nxt = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                REG_WE    = 1'b1;
                RF_WR_SEL = RF_WR_MEM;
                PC_WE     = 1'b1;
                state_nxt = ST_FETCH;
            end
            ST_TRAP: begin
                if (!RESET_TRAP_EXIT) begin
                    PC_WE     = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
        if (!RST_N) begin
            ALU_FUN   = '0;
            SRCA_SEL  = '0;
            SRCB_SEL  = '0;
            PC_SEL    = '0;
            RF_WR_SEL = '0;
            PC_WE     = 1'b0;
            REG_WE    = 1'b0;
            MEM_RDEN1 = 1'b0;
            MEM_RDEN2 = 1'b0;
            MEM_WE2   = 1'b0;
            ILLEGAL   = 1'b0;
        end
    end

endmodule
